// File: rtl/bp_nonsynth_cfg_responder_pkg.sv
// Shared types and constants for the config-space responder: memory message
// layout, local address map and the size-to-mask helper.
package bp_nonsynth_cfg_responder_pkg;

  localparam int paddr_width_p    = 40;
  localparam int cce_id_width_p   = 4;
  localparam int lce_id_width_p   = 4;
  localparam int dword_width_p    = 64;
  localparam int dev_width_p      = 4;
  localparam int dev_addr_width_p = 20;
  localparam int nonlocal_width_p = paddr_width_p - cce_id_width_p - dev_width_p - dev_addr_width_p;

  // Config device id and register map inside that device
  localparam logic [dev_width_p-1:0]      cfg_dev_gp           = 4'd2;
  localparam logic [dev_addr_width_p-1:0] bp_cfg_reg_freeze_gp = 20'h00008;
  // Scratch window starts right after the freeze register
  localparam logic [dev_addr_width_p-1:0] cfg_scratch_base_gp  = bp_cfg_reg_freeze_gp + 20'd1;

  typedef enum logic [2:0] {
    e_cce_mem_rd       = 3'd0,
    e_cce_mem_wr       = 3'd1,
    e_cce_mem_uc_rd    = 3'd2,
    e_cce_mem_wb       = 3'd3,
    e_cce_mem_pre      = 3'd4,
    e_cce_mem_uc_wr    = 3'd5,
    e_cce_mem_amo_swap = 3'd6,
    e_cce_mem_amo_add  = 3'd7
  } bp_cce_mem_cmd_type_e;

  typedef enum logic [2:0] {
    e_mem_size_1   = 3'd0,
    e_mem_size_2   = 3'd1,
    e_mem_size_4   = 3'd2,
    e_mem_size_8   = 3'd3,
    e_mem_size_16  = 3'd4,
    e_mem_size_32  = 3'd5,
    e_mem_size_64  = 3'd6,
    e_mem_size_128 = 3'd7
  } bp_mem_msg_size_e;

  typedef struct packed {
    logic [nonlocal_width_p-1:0] nonlocal;
    logic [cce_id_width_p-1:0]   cce;
    logic [dev_width_p-1:0]      dev;
    logic [dev_addr_width_p-1:0] addr;
  } bp_local_addr_s;

  typedef struct packed {
    logic [lce_id_width_p-1:0] lce_id;
    logic [2:0]                way_id;
  } bp_cce_mem_payload_s;

  typedef struct packed {
    bp_cce_mem_cmd_type_e     msg_type;
    logic [paddr_width_p-1:0] addr;
    bp_mem_msg_size_e         size;
    bp_cce_mem_payload_s      payload;
  } bp_cce_mem_msg_header_s;

  typedef struct packed {
    bp_cce_mem_msg_header_s   header;
    logic [dword_width_p-1:0] data;
  } bp_cce_mem_msg_s;

  localparam int cce_mem_msg_width_lp = $bits(bp_cce_mem_msg_s);

  // Keeps the low bytes named by the message size; anything wider than a
  // dword keeps the full dword.
  function automatic logic [dword_width_p-1:0] size_mask(input bp_mem_msg_size_e size);
    case (size)
      e_mem_size_1: size_mask = 64'h0000_0000_0000_00FF;
      e_mem_size_2: size_mask = 64'h0000_0000_0000_FFFF;
      e_mem_size_4: size_mask = 64'h0000_0000_FFFF_FFFF;
      default:      size_mask = 64'hFFFF_FFFF_FFFF_FFFF;
    endcase
  endfunction

endpackage

// File: rtl/bp_nonsynth_cfg_responder_if.sv
// I/O command/response link between the loader (master) and the config
// responder (slave).
interface bp_nonsynth_cfg_responder_if;
  import bp_nonsynth_cfg_responder_pkg::*;

  bp_cce_mem_msg_s io_cmd;
  logic            io_cmd_v;
  logic            io_cmd_yumi;
  bp_cce_mem_msg_s io_resp;
  logic            io_resp_v;
  logic            io_resp_ready;

  modport master (
    output io_cmd, io_cmd_v, io_resp_ready,
    input  io_cmd_yumi, io_resp, io_resp_v
  );

  modport slave (
    input  io_cmd, io_cmd_v, io_resp_ready,
    output io_cmd_yumi, io_resp, io_resp_v
  );

endinterface

// File: rtl/bp_cfg_regfile.sv
// Freeze bit plus scratch register array; writes land on the clock edge,
// reads are combinational so a read right after a write sees the new value.
module bp_cfg_regfile
  import bp_nonsynth_cfg_responder_pkg::*;
#(
  parameter int num_regs_p     = 8,
  parameter bit freeze_reset_p = 1'b1,
  localparam int idx_width_lp  = $clog2(num_regs_p)
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     freeze_w_v_i,
  input  logic                     scratch_w_v_i,
  input  logic [idx_width_lp-1:0]  idx_i,
  input  logic [dword_width_p-1:0] wdata_i,
  input  logic                     freeze_sel_i,
  output logic [dword_width_p-1:0] rdata_o,
  output logic                     freeze_o
);

  logic                     freeze_r;
  logic [dword_width_p-1:0] scratch_r [num_regs_p];

  // Register state: reset to defaults, otherwise apply the sized write
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      freeze_r <= freeze_reset_p;
      for (int i = 0; i < num_regs_p; i++) begin
        scratch_r[i] <= 64'd0;
      end
    end else begin
      if (freeze_w_v_i) begin
        freeze_r <= wdata_i[0];
      end
      if (scratch_w_v_i) begin
        scratch_r[idx_i] <= wdata_i;
      end
    end
  end

  // Read mux: freeze appears as a zero-extended single bit
  always_comb begin
    rdata_o = 64'd0;
    if (freeze_sel_i) begin
      rdata_o = {63'd0, freeze_r};
    end else begin
      rdata_o = scratch_r[idx_i];
    end
  end

  assign freeze_o = freeze_r;

endmodule

// File: rtl/bp_nonsynth_cfg_responder.sv
// Config-space endpoint on the I/O command channel: decodes uncached
// reads/writes to the local config device and returns one response per
// command through a single-entry response register.
module bp_nonsynth_cfg_responder
  import bp_nonsynth_cfg_responder_pkg::*;
#(
  parameter int num_regs_p     = 8,
  parameter bit freeze_reset_p = 1'b1
) (
  input  logic                      clk_i,
  input  logic                      reset_i,
  input  logic [cce_id_width_p-1:0] cce_id_i,
  bp_nonsynth_cfg_responder_if.slave cfg_link,
  output logic                      freeze_o,
  output logic                      err_o
);

  localparam int idx_width_lp = $clog2(num_regs_p);

  bp_cce_mem_msg_s             cmd_s;
  bp_local_addr_s              laddr_s;
  logic [dev_addr_width_p-1:0] offset_s;
  logic                        hit_s, freeze_sel_s, scratch_sel_s, mapped_s;
  logic                        is_rd_s, is_wr_s, bad_s, accept_s;
  logic [dword_width_p-1:0]    mask_s, wdata_s, rdata_s, resp_data_s;

  logic                        resp_v_r;
  bp_cce_mem_msg_s             resp_r;
  logic                        err_r;

  assign cmd_s   = cfg_link.io_cmd;
  assign laddr_s = cmd_s.header.addr;

  // Address decode; below-window addresses wrap to a large offset and miss
  assign hit_s         = (laddr_s.nonlocal == '0) & (laddr_s.cce == cce_id_i) & (laddr_s.dev == cfg_dev_gp);
  assign freeze_sel_s  = hit_s & (laddr_s.addr == bp_cfg_reg_freeze_gp);
  assign offset_s      = laddr_s.addr - cfg_scratch_base_gp;
  assign scratch_sel_s = hit_s & (offset_s < 20'(num_regs_p));
  assign mapped_s      = freeze_sel_s | scratch_sel_s;

  assign is_rd_s = (cmd_s.header.msg_type == e_cce_mem_uc_rd);
  assign is_wr_s = (cmd_s.header.msg_type == e_cce_mem_uc_wr);
  assign bad_s   = ~((is_rd_s | is_wr_s) & mapped_s);

  // Accept whenever the response slot is free or being drained this cycle
  assign accept_s = cfg_link.io_cmd_v & (~resp_v_r | cfg_link.io_resp_ready);

  assign mask_s  = size_mask(cmd_s.header.size);
  assign wdata_s = cmd_s.data & mask_s;

  bp_cfg_regfile #(
    .num_regs_p     (num_regs_p),
    .freeze_reset_p (freeze_reset_p)
  ) regfile (
    .clk_i         (clk_i),
    .reset_i       (reset_i),
    .freeze_w_v_i  (accept_s & is_wr_s & freeze_sel_s),
    .scratch_w_v_i (accept_s & is_wr_s & scratch_sel_s),
    .idx_i         (offset_s[idx_width_lp-1:0]),
    .wdata_i       (wdata_s),
    .freeze_sel_i  (freeze_sel_s),
    .rdata_o       (rdata_s),
    .freeze_o      (freeze_o)
  );

  // Response data: sized register value for mapped reads, zero otherwise
  always_comb begin
    resp_data_s = 64'd0;
    if (is_rd_s & mapped_s) begin
      resp_data_s = rdata_s & mask_s;
    end else begin
      resp_data_s = 64'd0;
    end
  end

  // Response-slot occupancy and sticky error flag
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      resp_v_r <= 1'b0;
      err_r    <= 1'b0;
    end else begin
      if (accept_s) begin
        resp_v_r <= 1'b1;
        err_r    <= err_r | bad_s;
      end else if (cfg_link.io_resp_ready) begin
        resp_v_r <= 1'b0;
      end
    end
  end

  // Response payload loads only on accept, so it holds while stalled
  always_ff @(posedge clk_i) begin
    if (accept_s) begin
      resp_r.header <= cmd_s.header;
      resp_r.data   <= resp_data_s;
    end
  end

  assign cfg_link.io_cmd_yumi = accept_s;
  assign cfg_link.io_resp     = resp_r;
  assign cfg_link.io_resp_v   = resp_v_r;
  assign err_o                = err_r;

endmodule
